// File: rtl/uart_rx_scheduler_if.sv
// Handshake bundle between the UART receivers, the shared
// word buffer and its downstream consumer.
interface uart_rx_scheduler_if #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 8,
  parameter int BUF_ADDR_SZ = 4
);
  localparam int CW = $clog2(CHANNELS);

  logic [CHANNELS-1:0]            rx_valid;
  logic [CHANNELS-1:0][WIDTH-1:0] rx_word;
  logic [CHANNELS-1:0]            rx_ack;
  logic                           rd_req;
  logic                           rd_valid;
  logic [WIDTH-1:0]               rd_data;
  logic [CW-1:0]                  rd_chan;
  logic [BUF_ADDR_SZ:0]           count;
  logic                           full;
  logic                           empty;
  logic [CHANNELS-1:0]            overflow;
  logic                           clr_overflow;

  modport master (
    output rx_valid, rx_word, rd_req, clr_overflow,
    input  rx_ack, rd_valid, rd_data, rd_chan,
    input  count, full, empty, overflow
  );

  modport slave (
    input  rx_valid, rx_word, rd_req, clr_overflow,
    output rx_ack, rd_valid, rd_data, rd_chan,
    output count, full, empty, overflow
  );
endinterface

// File: rtl/uart_rx_scheduler.sv
// Round-robin merge of several UART receivers into one
// circular buffer with a fall-through read port.
module uart_rx_scheduler #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 8,
  parameter int BUF_ADDR_SZ = 4
) (
  input logic                  clk,
  input logic                  rst,
  uart_rx_scheduler_if.slave   bus
);
  localparam int CW    = $clog2(CHANNELS);
  localparam int DEPTH = 2 ** BUF_ADDR_SZ;
  localparam logic [BUF_ADDR_SZ:0] FULL_CNT =
    {1'b1, {BUF_ADDR_SZ{1'b0}}};
  localparam logic [CW:0] NCH = (CW+1)'(CHANNELS);

  logic [BUF_ADDR_SZ-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUF_ADDR_SZ-1:0] rd_ptr_q, rd_ptr_d;
  logic [BUF_ADDR_SZ:0]   count_q, count_d;
  logic [CHANNELS-1:0]    ovf_q, ovf_d;
  logic [CW-1:0]          last_q, last_d;

  logic [CW+WIDTH-1:0] mem_q [DEPTH];

  logic          gnt_vld;
  logic [CW-1:0] gnt_idx;
  logic [CW:0]   arb_sum;
  logic          is_full, is_empty;
  logic          pop, wr, drop;

  assign is_full  = (count_q == FULL_CNT);
  assign is_empty = (count_q == '0);

  // Rotating priority search starting just after the last winner
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    arb_sum = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      arb_sum = {1'b0, last_q} + (CW+1)'(i);
      if (arb_sum >= NCH) arb_sum = arb_sum - NCH;
      if (!gnt_vld && bus.rx_valid[arb_sum[CW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = arb_sum[CW-1:0];
      end
    end
  end

  always_comb begin
    bus.rx_ack = '0;
    if (gnt_vld && !rst) bus.rx_ack[gnt_idx] = 1'b1;
  end

  assign pop  = bus.rd_req && !is_empty;
  assign wr   = gnt_vld && (!is_full || bus.rd_req);
  assign drop = gnt_vld && is_full && !bus.rd_req;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    ovf_d    = bus.clr_overflow ? '0 : ovf_q;
    if (wr)      wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (gnt_vld) last_d   = gnt_idx;
    if (drop)    ovf_d[gnt_idx] = 1'b1;
    unique case ({wr, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
      last_q   <= CW'(CHANNELS-1);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= {gnt_idx, bus.rx_word[gnt_idx]};
  end

  assign {bus.rd_chan, bus.rd_data} = mem_q[rd_ptr_q];

  assign bus.rd_valid = !is_empty;
  assign bus.count    = count_q;
  assign bus.full     = is_full;
  assign bus.empty    = is_empty;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_uart_rx_scheduler.sv
// Randomized bench for uart_rx_scheduler against a queue
// based model of the shared buffer and its arbiter.
module tb_uart_rx_scheduler;
  localparam int C  = 4;
  localparam int W  = 8;
  localparam int AS = 4;
  localparam int D  = 2 ** AS;

  typedef struct {
    int         c;
    logic [7:0] w;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_scheduler_if #(
    .CHANNELS(C), .WIDTH(W), .BUF_ADDR_SZ(AS)
  ) bus ();

  uart_rx_scheduler #(
    .CHANNELS(C), .WIDTH(W), .BUF_ADDR_SZ(AS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ent_t       q[$];
  int         mlast;
  logic [C-1:0] movf;
  bit         pend [C];
  logic [7:0] wd   [C];
  bit         rd_req;
  bit         clr;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mlast = C - 1;
    movf  = '0;
  endtask

  // One clock: drive inputs, check at negedge, advance model
  task automatic step();
    int g;
    bit was_full;
    ent_t e;
    for (int c = 0; c < C; c++) begin
      bus.rx_valid[c] = pend[c];
      bus.rx_word[c]  = wd[c];
    end
    bus.rd_req       = rd_req;
    bus.clr_overflow = clr;
    @(negedge clk);
    g = -1;
    for (int i = 1; i <= C; i++) begin
      int j;
      j = (mlast + i) % C;
      if (g < 0 && pend[j]) g = j;
    end
    chk("ack", 32'(bus.rx_ack), g < 0 ? 0 : (1 << g));
    chk("valid", 32'(bus.rd_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("data", 32'(bus.rd_data), 32'(q[0].w));
      chk("chan", 32'(bus.rd_chan), q[0].c);
    end
    chk("count", 32'(bus.count), q.size());
    chk("full", 32'(bus.full), 32'(q.size() == D));
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("ovf", 32'(bus.overflow), 32'(movf));
    was_full = (q.size() == D);
    if (rd_req && q.size() != 0) void'(q.pop_front());
    if (clr) movf = '0;
    if (g >= 0) begin
      if (!was_full || rd_req) begin
        e.c = g;
        e.w = wd[g];
        q.push_back(e);
      end else begin
        movf[g] = 1'b1;
      end
      pend[g] = 0;
      mlast   = g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_valid", 32'(bus.rd_valid), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_ack", 32'(bus.rx_ack), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(int c, logic [7:0] w);
    pend[c] = 1;
    wd[c]   = w;
    step();
  endtask

  initial begin
    for (int c = 0; c < C; c++) begin
      pend[c] = 1;
      wd[c]   = 8'(c);
    end
    bus.rx_valid     = '1;
    bus.rx_word      = '0;
    bus.rd_req       = 1'b0;
    bus.clr_overflow = 1'b0;
    rd_req = 0;
    clr    = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < C; c++) pend[c] = 0;
    bus.rx_valid = '0;
    do_reset();

    send(2, 8'hA5);
    step();
    rd_req = 1;
    step();
    rd_req = 0;

    do_reset();
    for (int c = 0; c < C; c++) begin
      pend[c] = 1;
      wd[c]   = 8'h10 + 8'(c);
    end
    repeat (4) step();
    rd_req = 1;
    repeat (4) step();
    rd_req = 0;
    step();

    for (int i = 0; i < D; i++)
      send($urandom_range(C - 1), 8'($urandom));
    send(1, 8'h77);
    step();
    clr = 1;
    step();
    clr = 0;
    step();

    rd_req = 1;
    send(3, 8'($urandom));
    repeat (D) step();
    rd_req = 0;
    step();

    rd_req = 1;
    repeat (5) step();
    rd_req = 0;
    send(0, 8'h3C);
    step();
    rd_req = 1;
    step();
    rd_req = 0;

    for (int i = 0; i < D; i++)
      send($urandom_range(C - 1), 8'($urandom));
    send(2, 8'h55);
    rd_req = 1;
    repeat (9) step();
    rd_req = 0;
    step();
    for (int c = 0; c < C; c++) begin
      pend[c] = 1;
      wd[c]   = 8'hC0 + 8'(c);
    end
    #3;
    chk("pre_rst_count", 32'(bus.count), 7);
    do_reset();
    step();
    chk("post_rst_first", 32'(q[q.size()-1].c), 0);
    rd_req = 1;
    repeat (8) step();
    rd_req = 0;

    for (int n = 0; n < 3000; n++) begin
      int pct;
      pct = ((n / 300) % 2 == 0) ? 25 : 80;
      for (int c = 0; c < C; c++)
        if (!pend[c] && $urandom_range(99) < 35) begin
          pend[c] = 1;
          wd[c]   = 8'($urandom);
        end
      rd_req = ($urandom_range(99) < pct);
      clr    = ($urandom_range(99) < 4);
      step();
    end
    rd_req = 0;
    clr    = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_scheduler.md
Name: uart_rx_scheduler

Overview:
Shares one circular word buffer between CHANNELS independent UART receivers. A round-robin arbiter accepts at most one received word per clock and stores it in the buffer, tagged with its source channel. The downstream consumer drains the buffer through a first-word-fall-through read port. Per-channel sticky overflow flags record words that were dropped because the buffer was full.

Parameters:
CHANNELS, 4, number of UART receivers sharing the buffer (2..16)
WIDTH, 8, data bits per received word
BUF_ADDR_SZ, 4, log2 of buffer depth (depth = 2**BUF_ADDR_SZ)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
rx_valid  in  CHANNELS  per-channel "word available"; held high until acked
rx_word  in  CHANNELS x WIDTH  per-channel received word; stable while rx_valid is high
rx_ack  out  CHANNELS  one-hot, combinational; high in the cycle the channel's word is consumed
rd_req  in  1  pop head entry at the next rising edge
rd_valid  out  1  buffer non-empty; rd_data and rd_chan are meaningful
rd_data  out  WIDTH  head word
rd_chan  out  $clog2(CHANNELS)  source channel of the head word
count  out  BUF_ADDR_SZ+1  number of stored entries, 0..depth
full  out  1  count == depth
empty  out  1  count == 0
overflow  out  CHANNELS  sticky per-channel drop flag
clr_overflow  in  1  clears all overflow bits

Behaviour:
- Reset (asynchronous, immediate): wr_ptr=0, rd_ptr=0, count=0, overflow=0, last_grant=CHANNELS-1.
  - Outputs under reset: rd_valid=0, empty=1, full=0, rx_ack=0.
  - Buffer RAM contents are not cleared; they are don't-care.
  - Reset asserted mid-transfer discards all stored words. A channel that still holds rx_valid high is re-arbitrated after reset is released.
- Arbitration, evaluated combinationally each cycle:
  - Search channels starting at (last_grant+1) mod CHANNELS, wrapping around.
  - The first channel with rx_valid=1 is granted; rx_ack for that channel goes high in the same cycle.
  - At the rising edge, last_grant takes the granted index. With no requester, last_grant holds.
  - At most one rx_ack bit is high per cycle.
- Write, at the rising edge with a grant:
  - If not full, or if full with rd_req=1 in the same cycle: store {channel id, word} at wr_ptr and increment wr_ptr modulo depth.
  - If full with no pop in the same cycle: the word is dropped, but rx_ack is still issued so the UART never stalls. overflow[granted] is set.
- Read:
  - rd_data and rd_chan reflect the entry at rd_ptr whenever rd_valid=1 (zero-latency fall-through).
  - rd_req with rd_valid=1 increments rd_ptr modulo depth at the edge.
  - rd_req while empty is ignored: no pointer or count change.
- Count update per edge: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop, unchanged on drop.
  - full and empty are derived from count; pointers alone never decide full or empty.
- Simultaneous write and pop when count==1: the old head is popped and the new word becomes the head next cycle. rd_valid stays 1.
- Pointer wrap-around: both pointers roll over from depth-1 to 0 with no gap.
- overflow:
  - Set on a drop.
  - clr_overflow=1 clears all bits at the edge.
  - If a drop and clr_overflow occur in the same cycle, the set for the dropping channel wins; all other bits clear.
- Latency: a granted word is visible on rd_data one cycle after its rx_ack when the buffer was empty.

Test Plan:
- Reset release, then channel 2 presents 0xA5 -> rx_ack=0b0100 that cycle; next cycle rd_valid=1, rd_data=0xA5, rd_chan=2, count=1.
- All 4 channels assert rx_valid simultaneously with words 0x10..0x13 -> acks in order ch0, ch1, ch2, ch3 on consecutive cycles; pops return 0x10, 0x11, 0x12, 0x13 with rd_chan 0..3.
- Fill 16 entries with no reads, then ch1 sends 0x77 -> rx_ack[1]=1, count stays 16, overflow=0b0010, head unchanged. Then clr_overflow -> overflow=0.
- Buffer full, ch3 write and rd_req in the same cycle -> count stays 16, no overflow, 0x?? of ch3 is stored as the tail. Drain all 16 -> last rd_data is ch3's word; wr_ptr and rd_ptr have wrapped to the same index; empty=1.
- rd_req held high while empty for 5 cycles -> count=0, rd_valid=0 throughout, no pointer movement (a subsequent write reads back correctly).
- Assert rst asynchronously mid-stream with count=7 -> count=0, empty=1, overflow=0 immediately without waiting for a clock edge; first grant after release goes to ch0 if all channels are requesting.
